// File: rtl/vga_frame_reader.sv
// Maps VGA scan positions onto a windowed grayscale frame buffer and emits RGB
// with the sync/blank signals delayed to match the frame-buffer read latency.
module vga_frame_reader #(
  parameter int         HACTIVE = 640,
  parameter int         VACTIVE = 480,
  parameter int         IMG_W   = 256,
  parameter int         IMG_H   = 256,
  parameter int         X0      = 192,
  parameter int         Y0      = 112,
  parameter int         ADDR_W  = 16,
  parameter int         RD_LAT  = 1,
  parameter logic [7:0] BORDER  = 8'h40
) (
  input  logic              vgaclk,
  input  logic              rst_n,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_b_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              sync_b,
  output logic              blank_b,
  output logic              frame_done
);

  if (X0 + IMG_W > HACTIVE) begin : g_bad_x
    $error("vga_frame_reader: image window exceeds HACTIVE");
  end
  if (Y0 + IMG_H > VACTIVE) begin : g_bad_y
    $error("vga_frame_reader: image window exceeds VACTIVE");
  end
  if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_bad_addr
    $error("vga_frame_reader: image does not fit in ADDR_W address space");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("vga_frame_reader: RD_LAT must be 1 or 2");
  end

  // 11-bit bounds so a window ending at column/line 1024 still compares correctly
  localparam logic [10:0]       X_LO     = 11'(X0);
  localparam logic [10:0]       X_HI     = 11'(X0 + IMG_W);
  localparam logic [10:0]       X_LAST   = 11'(X0 + IMG_W - 1);
  localparam logic [10:0]       X_EOL    = 11'(HACTIVE - 1);
  localparam logic [10:0]       Y_LO     = 11'(Y0);
  localparam logic [10:0]       Y_HI     = 11'(Y0 + IMG_H);
  localparam logic [10:0]       Y_LAST   = 11'(Y0 + IMG_H - 1);
  localparam logic [9:0]        X_OFF    = 10'(X0);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  typedef enum logic {WAIT_SOF, RUN} state_t;

  typedef struct packed {
    logic win;
    logic blank_b;
    logic hs;
    logic vs;
    logic last;
  } tag_t;

  localparam tag_t TAG_IDLE = '{win: 1'b0, blank_b: 1'b0, hs: 1'b1, vs: 1'b1, last: 1'b0};

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] row_base_reg, row_base_next;
  logic              sof, run, x_in, y_in, win, last;
  tag_t              tag_in, tag_out;

  logic [7:0] pix_reg;
  logic       hsync_reg, vsync_reg, blank_reg, done_reg;

  always_comb begin
    state_next    = state_reg;
    row_base_next = row_base_reg;
    mem_addr      = '0;
    sof           = (x == 10'd0) && (y == 10'd0);
    x_in          = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI);
    y_in          = ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
    // the start-of-frame cycle itself already belongs to RUN; nothing reads while in reset
    run           = rst_n && ((state_reg == RUN) || sof);
    win           = run && blank_b_in && x_in && y_in;
    last          = win && ({1'b0, x} == X_LAST) && ({1'b0, y} == Y_LAST);

    if (state_reg == WAIT_SOF && sof)
      state_next = RUN;

    if (sof)
      row_base_next = '0;
    else if (({1'b0, x} == X_EOL) && y_in)
      row_base_next = row_base_reg + ROW_STEP;

    if (win)
      mem_addr = (sof ? '0 : row_base_reg) + ADDR_W'(x - X_OFF);
  end

  assign mem_rd_en = win;

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= WAIT_SOF;
      row_base_reg <= '0;
    end else begin
      state_reg    <= state_next;
      row_base_reg <= row_base_next;
    end
  end

  assign tag_in = '{win: win, blank_b: blank_b_in && run, hs: hsync_in, vs: vsync_in, last: last};

  // Tag delay line matching the frame-buffer read latency
  genvar gi;
  for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
    tag_t stage_reg;
    if (gi == 0) begin : g_src
      always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) stage_reg <= TAG_IDLE;
        else        stage_reg <= tag_in;
      end
    end else begin : g_src
      always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) stage_reg <= TAG_IDLE;
        else        stage_reg <= g_stage[gi-1].stage_reg;
      end
    end
  end

  assign tag_out = g_stage[RD_LAT-1].stage_reg;

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_reg   <= 8'h00;
      hsync_reg <= 1'b1;
      vsync_reg <= 1'b1;
      blank_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      if (tag_out.win)
        pix_reg <= mem_rdata;
      else if (tag_out.blank_b)
        pix_reg <= BORDER;
      else
        pix_reg <= 8'h00;
      hsync_reg <= tag_out.hs;
      vsync_reg <= tag_out.vs;
      blank_reg <= tag_out.blank_b;
      done_reg  <= tag_out.last;
    end
  end

  assign red        = pix_reg;
  assign green      = pix_reg;
  assign blue       = pix_reg;
  assign hsync      = hsync_reg;
  assign vsync      = vsync_reg;
  assign sync_b     = hsync_reg & vsync_reg;
  assign blank_b    = blank_reg;
  assign frame_done = done_reg;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench: two readers (RD_LAT=1 and RD_LAT=2) share one compressed VGA scan,
// each with its own frame-buffer model returning addr[7:0]^addr[15:8].
module tb_vga_frame_reader;

  logic        vgaclk = 1'b0;
  logic        rst_n;
  logic [9:0]  x, y;
  logic        hsync_in, vsync_in, blank_b_in;

  logic [15:0] addr1, addr2;
  logic        en1, en2;
  logic [7:0]  rdata1, rdata2, rdata2_d;
  logic [7:0]  r1, g1, b1, r2, g2, b2;
  logic        hs1, vs1, sb1, bb1, fd1;
  logic        hs2, vs2, sb2, bb2, fd2;

  int n_cmp = 0;
  int n_err = 0;
  int fd_cnt1 = 0;
  int fd_cnt2 = 0;

  always #5 vgaclk = ~vgaclk;

  vga_frame_reader #(.RD_LAT(1)) dut1 (
    .vgaclk(vgaclk), .rst_n(rst_n), .x(x), .y(y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_b_in(blank_b_in),
    .mem_addr(addr1), .mem_rd_en(en1), .mem_rdata(rdata1),
    .red(r1), .green(g1), .blue(b1),
    .hsync(hs1), .vsync(vs1), .sync_b(sb1), .blank_b(bb1), .frame_done(fd1)
  );

  vga_frame_reader #(.RD_LAT(2)) dut2 (
    .vgaclk(vgaclk), .rst_n(rst_n), .x(x), .y(y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_b_in(blank_b_in),
    .mem_addr(addr2), .mem_rd_en(en2), .mem_rdata(rdata2),
    .red(r2), .green(g2), .blue(b2),
    .hsync(hs2), .vsync(vs2), .sync_b(sb2), .blank_b(bb2), .frame_done(fd2)
  );

  always @(posedge vgaclk) begin
    rdata1   <= addr1[7:0] ^ addr1[15:8];
    rdata2_d <= addr2[7:0] ^ addr2[15:8];
    rdata2   <= rdata2_d;
  end

  always @(negedge vgaclk) begin
    if (fd1 === 1'b1) fd_cnt1 <= fd_cnt1 + 1;
    if (fd2 === 1'b1) fd_cnt2 <= fd_cnt2 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_px1(input string tag, input int v);
    logic [7:0] e;
    e = 8'(v);
    chk({tag, "_rgb1"}, {8'h00, r1, g1, b1}, {8'h00, e, e, e});
  endtask

  task automatic chk_px2(input string tag, input int v);
    logic [7:0] e;
    e = 8'(v);
    chk({tag, "_rgb2"}, {8'h00, r2, g2, b2}, {8'h00, e, e, e});
  endtask

  task automatic chk_addr(input string tag, input int a, input logic en);
    chk({tag, "_addr1"}, {16'h0, addr1}, 32'(a));
    chk({tag, "_en1"}, {31'h0, en1}, {31'h0, en});
    chk({tag, "_addr2"}, {16'h0, addr2}, 32'(a));
    chk({tag, "_en2"}, {31'h0, en2}, {31'h0, en});
  endtask

  // rgb, hsync, vsync, sync_b, blank_b, frame_done, rd_en, then address
  task automatic chk_rst(input string tag);
    chk({tag, "_out1"}, {r1, g1, b1, hs1, vs1, sb1, bb1, fd1, en1}, {24'h0, 6'b111000});
    chk({tag, "_out2"}, {r2, g2, b2, hs2, vs2, sb2, bb2, fd2, en2}, {24'h0, 6'b111000});
    chk({tag, "_maddr"}, {addr1, addr2}, 32'h0);
  endtask

  // one pixel of a 640x480 timing controller (hsync 656..751, vsync lines 490..491)
  task automatic pix(input int px, input int py);
    @(negedge vgaclk);
    x          = 10'(px);
    y          = 10'(py);
    hsync_in   = !(px >= 656 && px < 752);
    vsync_in   = !(py == 490 || py == 491);
    blank_b_in = (px < 640) && (py < 480);
    #1;
  endtask

  // Compressed frame: each line visits x=0, any directed pixels, x=639 and x=700.
  task automatic frame();
    for (int yy = 0; yy < 525; yy++) begin
      pix(0, yy);
      if (yy == 10) begin
        pix(700, 10);  chk_addr("blank_rd", 0, 1'b0);
        pix(701, 10);  chk_px1("border_pre", 8'h40); chk("border_pre_bb1", {31'h0, bb1}, 1);
        pix(702, 10);  chk_px1("blank", 0); chk("blank_bb1", {31'h0, bb1}, 0);
                       chk_px2("border_pre", 8'h40);
        pix(703, 10);  chk_px2("blank", 0); chk("blank_bb2", {31'h0, bb2}, 0);
      end
      if (yy == 100) begin
        pix(655, 100);
        pix(656, 100);
        pix(657, 100); chk("hs_pre1", {31'h0, hs1}, 1); chk("sb_pre1", {31'h0, sb1}, 1);
        pix(658, 100); chk("hs_fall1", {31'h0, hs1}, 0); chk("sb_h1", {31'h0, sb1}, 0);
                       chk("hs_pre2", {31'h0, hs2}, 1);
        pix(659, 100); chk("hs_fall2", {31'h0, hs2}, 0); chk("sb_h2", {31'h0, sb2}, 0);
      end
      if (yy == 112) begin
        pix(192, 112); chk_addr("rd_192_112", 0, 1'b1);
        pix(193, 112); chk_addr("rd_193_112", 1, 1'b1);
        pix(194, 112); chk_px1("px_192_112", 0);
        pix(195, 112); chk_px1("px_193_112", 1); chk_px2("px_192_112", 0);
        pix(196, 112); chk_px1("px_194_112", 2); chk_px2("px_193_112", 1);
      end
      if (yy == 113) begin
        pix(192, 113); chk_addr("rd_192_113", 256, 1'b1);
        pix(193, 113);
        pix(194, 113); chk_px1("px_192_113", 1);
        pix(195, 113); chk_px1("px_193_113", 0); chk_px2("px_192_113", 1);
      end
      if (yy == 200) begin
        pix(100, 200); chk_addr("rd_100_200", 0, 1'b0);
        pix(101, 200);
        pix(102, 200); chk_px1("border", 8'h40); chk("border_bb1", {31'h0, bb1}, 1);
        pix(103, 200); chk_px2("border", 8'h40); chk("border_bb2", {31'h0, bb2}, 1);
      end
      if (yy == 367) begin
        pix(446, 367); chk_addr("rd_446_367", 65534, 1'b1);
        pix(447, 367); chk_addr("rd_447_367", 65535, 1'b1); chk("fd_early1", {31'h0, fd1}, 0);
        pix(448, 367); chk_px1("px_446_367", 1); chk("fd_pre1", {31'h0, fd1}, 0);
        pix(449, 367); chk_px1("px_447_367", 0); chk("fd_hit1", {31'h0, fd1}, 1);
                       chk_px2("px_446_367", 1); chk("fd_pre2", {31'h0, fd2}, 0);
        pix(450, 367); chk_px1("px_448_367", 8'h40); chk("fd_post1", {31'h0, fd1}, 0);
                       chk_px2("px_447_367", 0); chk("fd_hit2", {31'h0, fd2}, 1);
        pix(451, 367); chk("fd_post2", {31'h0, fd2}, 0);
      end
      if (yy == 490) begin
        pix(1, 490);   chk("vs_pre1", {31'h0, vs1}, 1); chk("vs_pre2a", {31'h0, vs2}, 1);
        pix(2, 490);   chk("vs_fall1", {31'h0, vs1}, 0); chk("sb_v1", {31'h0, sb1}, 0);
                       chk("vs_pre2b", {31'h0, vs2}, 1);
        pix(3, 490);   chk("vs_fall2", {31'h0, vs2}, 0); chk("sb_v2", {31'h0, sb2}, 0);
      end
      pix(639, yy);
      pix(700, yy);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    x          = 10'd192;
    y          = 10'd112;
    hsync_in   = 1'b1;
    vsync_in   = 1'b1;
    blank_b_in = 1'b1;
    repeat (3) @(negedge vgaclk);
    #1;
    chk_rst("reset");

    @(negedge vgaclk);
    rst_n = 1'b1;

    // before the first start of frame nothing is read and the pipeline stays blank
    pix(192, 112); chk_addr("presof", 0, 1'b0);
    pix(193, 112);
    pix(194, 112); chk_px1("presof", 0); chk("presof_bb1", {31'h0, bb1}, 0);
    pix(195, 112); chk_px2("presof", 0); chk("presof_bb2", {31'h0, bb2}, 0);

    frame();
    frame();
    frame();
    chk("fd_count1_3fr", 32'(fd_cnt1), 3);
    chk("fd_count2_3fr", 32'(fd_cnt2), 3);

    // partial frame, then reset mid-frame inside the image window
    for (int yy = 0; yy < 300; yy++) begin
      pix(0, yy);
      pix(639, yy);
      pix(700, yy);
    end
    pix(320, 300); chk_addr("rd_320_300", 188 * 256 + 128, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_rst("async_rst");
    @(posedge vgaclk);
    #1;
    chk_rst("hold_rst");
    @(negedge vgaclk);
    rst_n = 1'b1;

    for (int yy = 300; yy < 525; yy++) begin
      pix(0, yy);
      pix(320, yy); chk("norun_en1", {31'h0, en1}, 0);
      if (yy == 367) begin
        pix(447, 367); chk_addr("norun_last", 0, 1'b0);
      end
      pix(639, yy);
      pix(700, yy);
    end
    chk("fd_count1_rst", 32'(fd_cnt1), 3);
    chk("fd_count2_rst", 32'(fd_cnt2), 3);

    frame();
    chk("fd_count1_4fr", 32'(fd_cnt1), 4);
    chk("fd_count2_4fr", 32'(fd_cnt2), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
